lstm_param_store: RTL and testbench
===================================

Name: lstm_param_store

Overview:
- Parametrised, sequential successor to the flat parameter loader feeding the LSTM forward pass.
- Accepts the trained parameter stream one BW-bit word per beat over a valid/ready handshake and writes it into an internal word-addressed memory.
- Tracks segment, row and column boundaries on the fly and checks stream length against the model geometry.
- Serves registered random reads addressed by (segment, row, col), so a time-multiplexed gate engine can fetch weights without a 6002-word flattened bus.

Parameters:
- BW, 32, parameter word width (fixed-point word).
- ENC, 27, one-hot encoding width (input size and output size).
- HID, 25, hidden-state size.
- NUM_PARAMS, 4*(HID*(HID+ENC)+HID)+ENC*HID+ENC, total words (6002 at defaults). Derived; must not be overridden.
- CW, $clog2(NUM_PARAMS+1), width of the counter and address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new load; pulse.
- s_valid  in  1  stream word valid.
- s_ready  out  1  store accepts a word.
- s_data  in  BW  parameter word.
- s_last  in  1  final word of the stream.
- loaded  out  1  full, correct image present.
- err  out  1  stream length error, sticky until the next start.
- word_count  out  CW  words accepted in the current load.
- rd_en  in  1  read request.
- rd_seg  in  4  segment select: 0 wf, 1 bf, 2 wi, 3 bi, 4 wc, 5 bc, 6 wo, 7 bo, 8 wy, 9 by.
- rd_row  in  8  row index.
- rd_col  in  8  column index.
- rd_valid  out  1  rd_data valid.
- rd_data  out  BW  read word.
- rd_oob  out  1  the last read was out of range.
- chk_sum  out  BW  stream checksum (see Optional Feature).

Behaviour:
- Memory layout, in stream order, for each gate in the order f, i, c, o:
  - gate weights: HID rows x (HID+ENC) cols, row-major;
  - gate bias: HID rows x 1 col.
  - These are followed by wy (ENC rows x HID cols) and by (ENC rows x 1 col).
- Segment bases are compile-time constants derived from the parameters.
- Read address = base[seg] + row*cols[seg] + col.
- State machine has four states: IDLE, LOAD, READY, ERROR.
- Reset, asynchronous:
  - state goes to IDLE;
  - s_ready, loaded, err, rd_valid and rd_oob go to 0;
  - word_count, rd_data and chk_sum go to 0;
  - memory contents are not cleared.
- start from any state:
  - next state is LOAD;
  - word_count is cleared, along with the internal seg/row/col counters and the checksum;
  - loaded and err are cleared;
  - start has priority over a same-cycle handshake, and that beat is discarded.
- LOAD:
  - s_ready is 1.
  - On s_valid&s_ready, s_data is written at address word_count, and word_count increments.
  - Each beat also advances col, then row at cols[seg]-1, then seg at the last row.
  - If s_last arrives at word_count==NUM_PARAMS-1: next state is READY and loaded is 1 from the next cycle.
  - If s_last arrives at any earlier count: the word is written, next state is ERROR and err is 1.
  - If a word is accepted at NUM_PARAMS-1 without s_last: next state is ERROR and err is 1.
- READY:
  - s_ready is 0.
  - rd_en has 1-cycle latency: rd_valid is 1 in the cycle after rd_en and 0 otherwise.
  - Back-to-back reads are allowed, one per cycle.
  - Out of range means seg>9, row>=rows[seg] or col>=cols[seg]. Such a read returns rd_data=0 with rd_oob=1, and the memory is not accessed.
  - rd_oob updates on every rd_valid.
- IDLE, LOAD and ERROR:
  - rd_en is ignored; rd_valid stays 0.
  - s_ready is 0 in IDLE and ERROR.
- Reset in the middle of a load leaves IDLE with loaded=0. A partial image is never reported as loaded.
- No write path other than the stream. Memory is inferred as single-write, single-read synchronous RAM.

Optional Feature:
- Macro: PARAM_CHECKSUM_EN.
- Defined:
  - chk_sum is a running sum, modulo 2^BW, of every accepted s_data in the current load;
  - it is cleared on start and rst;
  - it holds its final value in READY and ERROR.
- Undefined: chk_sum is constant 0 and no adder is synthesised.

Test Plan:
- rst, start, then 6002 words with s_data=index and s_last on word 6001: loaded=1 at T+1, err=0, word_count=6002.
- After that load, read seg=0,row=1,col=0: rd_data=52, rd_valid one cycle later. Read seg=9,row=26,col=0: rd_data=6001.
- Read seg=1,row=0,col=1: rd_oob=1, rd_data=0. Read seg=10: rd_oob=1.
- Load with s_last on word 100: err=1, loaded=0, state ERROR. rd_en then gives rd_valid=0. A new start clears err.
- Load 6002 words with no s_last: err=1 after beat 6001. Beat 6001 under s_valid with start high is discarded, and word_count=0.
- rst asserted at word 3000: all outputs 0 immediately. Following full load with PARAM_CHECKSUM_EN and s_data=1: chk_sum=6002.

Source files
------------

// File: rtl/lstm_param_store.sv
// ---------------------------------------------------------------------------
// lstm_param_store
//
// Purpose:
//   Receives the trained LSTM parameter stream, one BW-bit word per beat over
//   a valid/ready handshake, and writes it into an inferred word-addressed RAM.
//   While loading it tracks segment, row and column boundaries and checks the
//   stream length against the model geometry. Once a complete image is present
//   it serves registered random reads addressed by (segment, row, col).
//
//   Segment order in the stream / memory:
//     0 wf, 1 bf, 2 wi, 3 bi, 4 wc, 5 bc, 6 wo, 7 bo, 8 wy, 9 by
//   Gate weights are HID x (HID+ENC), gate biases HID x 1,
//   wy is ENC x HID and by is ENC x 1, all row-major.
//
// Optional feature:
//   `define PARAM_CHECKSUM_EN to build a running modulo-2^BW sum of all
//   accepted words on chk_sum. Without it chk_sum is tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             pulse: begin a new load (wins over a same-cycle beat)
//   s_valid/s_ready   stream handshake; s_data word, s_last final word
//   loaded            a complete, correctly sized image is present
//   err               stream length error, sticky until the next start
//   word_count        words accepted in the current load
//   rd_en/rd_seg/rd_row/rd_col   read request (honoured in READY only)
//   rd_valid/rd_data/rd_oob      read response, one cycle after rd_en
//   chk_sum           stream checksum (0 unless PARAM_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module lstm_param_store #(
  parameter  int BW         = 32,
  parameter  int ENC        = 27,
  parameter  int HID        = 25,
  localparam int NUM_PARAMS = 4 * (HID * (HID + ENC) + HID) + ENC * HID + ENC,
  localparam int CW         = $clog2(NUM_PARAMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [BW-1:0] s_data,
  input  logic          s_last,
  output logic          loaded,
  output logic          err,
  output logic [CW-1:0] word_count,
  input  logic          rd_en,
  input  logic [3:0]    rd_seg,
  input  logic [7:0]    rd_row,
  input  logic [7:0]    rd_col,
  output logic          rd_valid,
  output logic [BW-1:0] rd_data,
  output logic          rd_oob,
  output logic [BW-1:0] chk_sum
);

  // Geometry of one gate: weight block followed by its bias column.
  localparam int WCOLS = HID + ENC;
  localparam int WSZ   = HID * WCOLS;
  localparam int GSZ   = WSZ + HID;

  typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_t;

  function automatic logic [7:0] seg_rows(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: return 8'(HID);
      4'd8, 4'd9:             return 8'(ENC);
      default:                return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] seg_cols(input logic [3:0] s);
    case (s)
      4'd0, 4'd2, 4'd4, 4'd6: return 8'(WCOLS);
      4'd1, 4'd3, 4'd5, 4'd7: return 8'd1;
      4'd8:                   return 8'(HID);
      4'd9:                   return 8'd1;
      default:                return 8'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] seg_base(input logic [3:0] s);
    case (s)
      4'd0:    return CW'(0);
      4'd1:    return CW'(WSZ);
      4'd2:    return CW'(GSZ);
      4'd3:    return CW'(GSZ + WSZ);
      4'd4:    return CW'(2 * GSZ);
      4'd5:    return CW'(2 * GSZ + WSZ);
      4'd6:    return CW'(3 * GSZ);
      4'd7:    return CW'(3 * GSZ + WSZ);
      4'd8:    return CW'(4 * GSZ);
      4'd9:    return CW'(4 * GSZ + ENC * HID);
      default: return CW'(0);
    endcase
  endfunction

  state_t        r_state;
  logic          r_s_ready;
  logic          r_loaded;
  logic          r_err;
  logic [CW-1:0] r_count;
  logic [3:0]    r_seg;
  logic [7:0]    r_row;
  logic [7:0]    r_col;
  logic          r_rd_valid;
  logic          r_rd_oob;
  logic          r_rd_keep;
  logic [BW-1:0] r_ram_q;
  logic [BW-1:0] r_mem [NUM_PARAMS];

  logic          w_fire;
  logic          w_at_end;
  logic          w_rd_fire;
  logic          w_in_range;
  logic [CW-1:0] w_rd_addr;

  // s_ready is only ever high in LOAD, so a handshake implies LOAD.
  // start discards the beat presented in the same cycle.
  assign w_fire    = s_valid & r_s_ready & ~start;
  assign w_at_end  = (r_count == CW'(NUM_PARAMS - 1));
  assign w_rd_fire = rd_en & (r_state == READY) & ~start;

  assign w_in_range = (rd_seg <= 4'd9) &&
                      (rd_row < seg_rows(rd_seg)) &&
                      (rd_col < seg_cols(rd_seg));

  // Only meaningful when w_in_range; the largest in-range address fits CW bits.
  assign w_rd_addr = seg_base(rd_seg) + CW'(rd_row) * CW'(seg_cols(rd_seg)) + CW'(rd_col);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
      r_seg     <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else if (start) begin
      r_state   <= LOAD;
      r_s_ready <= 1'b1;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
      r_seg     <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_fire) begin
            r_count <= r_count + CW'(1);
            // col wraps at the segment width, row at the segment height.
            if (r_col == seg_cols(r_seg) - 8'd1) begin
              r_col <= '0;
              if (r_row == seg_rows(r_seg) - 8'd1) begin
                r_row <= '0;
                r_seg <= r_seg + 4'd1;
              end else begin
                r_row <= r_row + 8'd1;
              end
            end else begin
              r_col <= r_col + 8'd1;
            end
            if (s_last || w_at_end) begin
              r_s_ready <= 1'b0;
              if (s_last && w_at_end) begin
                r_state  <= READY;
                r_loaded <= 1'b1;
              end else begin
                r_state <= ERROR;
                r_err   <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read response flags. r_rd_keep gates the RAM output so that rd_data is 0
  // after reset and after an out-of-range read without touching the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_rd_keep  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_oob  <= ~w_in_range;
        r_rd_keep <= w_in_range;
      end
    end
  end

  // Single-write, single-read synchronous RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_fire)
      r_mem[r_count] <= s_data;
    if (w_rd_fire && w_in_range)
      r_ram_q <= r_mem[w_rd_addr];
  end

`ifdef PARAM_CHECKSUM_EN
  logic [BW-1:0] r_chk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_chk <= '0;
    else if (start)
      r_chk <= '0;
    else if (w_fire)
      r_chk <= r_chk + s_data;
  end

  assign chk_sum = r_chk;
`else
  assign chk_sum = '0;
`endif

  assign s_ready    = r_s_ready;
  assign loaded     = r_loaded;
  assign err        = r_err;
  assign word_count = r_count;
  assign rd_valid   = r_rd_valid;
  assign rd_oob     = r_rd_oob;
  assign rd_data    = r_rd_keep ? r_ram_q : '0;

endmodule

// File: tb/tb_lstm_param_store.sv
// ---------------------------------------------------------------------------
// tb_lstm_param_store
//
// Directed bench for lstm_param_store at default geometry (6002 words).
// Read vectors are a table of {seg,row,col} with hand-computed addresses;
// load/error/reset corner cases are short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_lstm_param_store;

  localparam int BW  = 32;
  localparam int NP  = 6002;
  localparam int CW  = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          s_last;
  logic          loaded;
  logic          err;
  logic [CW-1:0] word_count;
  logic          rd_en;
  logic [3:0]    rd_seg;
  logic [7:0]    rd_row;
  logic [7:0]    rd_col;
  logic          rd_valid;
  logic [BW-1:0] rd_data;
  logic          rd_oob;
  logic [BW-1:0] chk_sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lstm_param_store dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .loaded     (loaded),
    .err        (err),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_seg     (rd_seg),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_oob     (rd_oob),
    .chk_sum    (chk_sum)
  );

  typedef struct {
    logic [3:0]  seg;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] data;
    logic        oob;
  } rd_vec_t;

  rd_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents beats 0..n-1; a beat counts when s_ready was high at the
  // negedge it was driven on. last_at < 0 means s_last is never raised.
  task automatic stream(input int n, input int last_at, input logic const_one);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < n + 50) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = const_one ? 32'd1 : 32'(i);
      s_last  = (i == last_at);
      if (s_ready) i++;
      guard++;
    end
    if (i < n) check("stream_timeout", 32'(i), 32'(n));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},    32'(s_ready),    32'd0);
    check({tag, "_loaded"},     32'(loaded),     32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
    check({tag, "_rd_data"},    rd_data,         32'd0);
    check({tag, "_rd_oob"},     32'(rd_oob),     32'd0);
    check({tag, "_chk_sum"},    chk_sum,         32'd0);
  endtask

  initial begin
    logic [31:0] exp_sum_idx;
    logic [31:0] exp_sum_one;
`ifdef PARAM_CHECKSUM_EN
    exp_sum_idx = 32'd18009001;  // 0+1+...+6001
    exp_sum_one = 32'd6002;
`else
    exp_sum_idx = 32'd0;
    exp_sum_one = 32'd0;
`endif

    // Addresses: bases 0,1300,1325,2625,2650,3950,3975,5275,5300,5975.
    vecs[0]  = '{4'd0,  8'd1,  8'd0,  32'd52,   1'b0};
    vecs[1]  = '{4'd9,  8'd26, 8'd0,  32'd6001, 1'b0};
    vecs[2]  = '{4'd1,  8'd0,  8'd1,  32'd0,    1'b1};
    vecs[3]  = '{4'd10, 8'd0,  8'd0,  32'd0,    1'b1};
    vecs[4]  = '{4'd0,  8'd0,  8'd0,  32'd0,    1'b0};
    vecs[5]  = '{4'd1,  8'd0,  8'd0,  32'd1300, 1'b0};
    vecs[6]  = '{4'd2,  8'd24, 8'd51, 32'd2624, 1'b0};
    vecs[7]  = '{4'd8,  8'd26, 8'd24, 32'd5974, 1'b0};
    vecs[8]  = '{4'd8,  8'd0,  8'd25, 32'd0,    1'b1};
    vecs[9]  = '{4'd6,  8'd25, 8'd0,  32'd0,    1'b1};
    vecs[10] = '{4'd7,  8'd3,  8'd0,  32'd5278, 1'b0};
    vecs[11] = '{4'd4,  8'd10, 8'd7,  32'd3177, 1'b0};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    rd_en = 1'b0; rd_seg = '0; rd_row = '0; rd_col = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Full correct load, s_data = index.
    pulse_start();
    check("start_s_ready", 32'(s_ready), 32'd1);
    stream(NP, NP - 1, 1'b0);
    check("load_loaded",     32'(loaded),     32'd1);
    check("load_err",        32'(err),        32'd0);
    check("load_word_count", 32'(word_count), 32'd6002);
    check("load_s_ready",    32'(s_ready),    32'd0);
    check("load_chk_sum",    chk_sum,         exp_sum_idx);
    check("idle_rd_valid",   32'(rd_valid),   32'd0);

    // Back-to-back table reads, one per cycle.
    rd_en = 1'b1;
    rd_seg = vecs[0].seg; rd_row = vecs[0].row; rd_col = vecs[0].col;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("rd%0d_valid", i), 32'(rd_valid), 32'd1);
      check($sformatf("rd%0d_oob", i),   32'(rd_oob),   32'(vecs[i].oob));
      check($sformatf("rd%0d_data", i),  rd_data,       vecs[i].data);
      if (i < 11) begin
        rd_seg = vecs[i+1].seg; rd_row = vecs[i+1].row; rd_col = vecs[i+1].col;
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    check("rd_valid_drop", 32'(rd_valid), 32'd0);

    // Early s_last on word 100.
    pulse_start();
    check("restart_loaded", 32'(loaded), 32'd0);
    stream(101, 100, 1'b0);
    check("early_err",        32'(err),        32'd1);
    check("early_loaded",     32'(loaded),     32'd0);
    check("early_s_ready",    32'(s_ready),    32'd0);
    check("early_word_count", 32'(word_count), 32'd101);
    rd_en = 1'b1; rd_seg = 4'd0; rd_row = 8'd0; rd_col = 8'd0;
    @(negedge clk);
    check("err_rd_valid_a", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("err_rd_valid_b", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    pulse_start();
    check("restart_err",        32'(err),        32'd0);
    check("restart_word_count", 32'(word_count), 32'd0);
    check("restart_s_ready",    32'(s_ready),    32'd1);

    // 6002 words without s_last.
    stream(NP, -1, 1'b0);
    check("nolast_err",        32'(err),        32'd1);
    check("nolast_loaded",     32'(loaded),     32'd0);
    check("nolast_word_count", 32'(word_count), 32'd6002);
    check("nolast_s_ready",    32'(s_ready),    32'd0);

    // Beat 6001 coincides with start: beat is discarded, count restarts.
    pulse_start();
    stream(NP - 1, -1, 1'b0);
    check("pre_start_count", 32'(word_count), 32'd6001);
    s_valid = 1'b1; s_data = 32'd6001; start = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; start = 1'b0;
    check("prio_word_count", 32'(word_count), 32'd0);
    check("prio_err",        32'(err),        32'd0);
    check("prio_loaded",     32'(loaded),     32'd0);
    check("prio_s_ready",    32'(s_ready),    32'd1);

    // Reset in the middle of a load, at word 3000.
    stream(3000, -1, 1'b0);
    check("mid_word_count", 32'(word_count), 32'd3000);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_loaded", 32'(loaded), 32'd0);

    // Full load of ones.
    pulse_start();
    stream(NP, NP - 1, 1'b1);
    check("ones_loaded",     32'(loaded),     32'd1);
    check("ones_word_count", 32'(word_count), 32'd6002);
    check("ones_chk_sum",    chk_sum,         exp_sum_one);
    rd_en = 1'b1; rd_seg = 4'd0; rd_row = 8'd1; rd_col = 8'd0;
    @(negedge clk);
    rd_en = 1'b0;
    check("ones_rd_valid", 32'(rd_valid), 32'd1);
    check("ones_rd_data",  rd_data,       32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
